// File: rtl/axis_mux_pkg.sv
// Shared definitions for the AXI-Stream N:1 bus multiplexer: selection code
// layout, lock FSM state type and the selection-code decode helper.
package axis_mux_pkg;

    localparam int unsigned SEL_EN_BIT = 7;
    localparam int unsigned SEL_IDX_W  = 7;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } mux_state_t;

    // A selection code is usable only with the enable bit set and an in-range index.
    function automatic logic sel_is_valid(input logic [7:0] sel, input int unsigned num_ch);
        return sel[SEL_EN_BIT] && (32'(sel[SEL_IDX_W-1:0]) < num_ch);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry fully registered AXI-Stream skid buffer: the output register is
// entry 0, the skid register entry 1; s_ready is a plain register decode.
module axis_skid_buf
    import axis_mux_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last,
    input  logic              m_ready
);

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [KEEP_W-1:0] skid_keep;
    logic              skid_last;
    logic              push;

    assign s_ready = ~skid_valid;
    assign push    = s_valid & s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
        end else if (skid_valid) begin
            // Skid occupied implies the output register is occupied too.
            if (m_ready) begin
                m_data     <= skid_data;
                m_keep     <= skid_keep;
                m_last     <= skid_last;
                skid_valid <= 1'b0;
            end
        end else if (push) begin
            if (!m_valid || m_ready) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_keep  <= s_keep;
                m_last  <= s_last;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= s_data;
                skid_keep  <= s_keep;
                skid_last  <= s_last;
            end
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_bus_mux_n.sv
// NUM_CH:1 AXI-Stream multiplexer with packet locking and a registered skid
// output. Define AXIS_MUX_PKT_CNT_EN to add the pkt_cnt output packet counter.
module axis_bus_mux_n
    import axis_mux_pkg::*;
#(
    parameter  int unsigned NUM_CH = 6,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned KEEP_W = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               bus_sel,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     busy
`ifdef AXIS_MUX_PKT_CNT_EN
    ,
    output logic [31:0]              pkt_cnt
`endif
);

    mux_state_t           state;
    logic [SEL_IDX_W-1:0] lock_idx;
    logic [SEL_IDX_W-1:0] act_idx;
    logic                 act_valid;
    logic                 buf_ready;
    logic                 mux_valid;
    logic [DATA_W-1:0]    mux_data;
    logic [KEEP_W-1:0]    mux_keep;
    logic                 mux_last;
    logic                 push;

    always_comb begin
        if (state == LOCK) begin
            act_idx   = lock_idx;
            act_valid = 1'b1;
        end else begin
            act_idx   = bus_sel[SEL_IDX_W-1:0];
            act_valid = sel_is_valid(bus_sel, NUM_CH);
        end
    end

    always_comb begin
        mux_valid     = 1'b0;
        mux_data      = '0;
        mux_keep      = '0;
        mux_last      = 1'b0;
        s_axis_tready = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (act_valid && (act_idx == SEL_IDX_W'(i))) begin
                mux_valid        = s_axis_tvalid[i];
                mux_data         = s_axis_tdata[i*DATA_W +: DATA_W];
                mux_keep         = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                mux_last         = s_axis_tlast[i];
                s_axis_tready[i] = buf_ready;
            end
        end
    end

    assign push = mux_valid & buf_ready;

    // busy is kept as its own flop, updated in lockstep with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_idx <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push && !mux_last) begin
                        state    <= LOCK;
                        lock_idx <= act_idx;
                        busy     <= 1'b1;
                    end
                end
                LOCK: begin
                    if (push && mux_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    axis_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (mux_valid),
        .s_data  (mux_data),
        .s_keep  (mux_keep),
        .s_last  (mux_last),
        .s_ready (buf_ready),
        .m_valid (m_axis_tvalid),
        .m_data  (m_axis_tdata),
        .m_keep  (m_axis_tkeep),
        .m_last  (m_axis_tlast),
        .m_ready (m_axis_tready)
    );

`ifdef AXIS_MUX_PKT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_cnt <= pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_bus_mux_n.sv
// Self-checking bench for axis_bus_mux_n against a queue-based behavioural model.
module tb_axis_bus_mux_n;

    localparam int NUM_CH = 6;
    localparam int DATA_W = 32;
    localparam int KEEP_W = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    logic                     clk;
    logic                     rst_n;
    logic [7:0]               bus_sel;
    logic [NUM_CH-1:0]        s_axis_tvalid;
    logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
    logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep;
    logic [NUM_CH-1:0]        s_axis_tlast;
    logic [NUM_CH-1:0]        s_axis_tready;
    logic                     m_axis_tvalid;
    logic [DATA_W-1:0]        m_axis_tdata;
    logic [KEEP_W-1:0]        m_axis_tkeep;
    logic                     m_axis_tlast;
    logic                     m_axis_tready;
    logic                     busy;
`ifdef AXIS_MUX_PKT_CNT_EN
    logic [31:0]              pkt_cnt;
`endif

    axis_bus_mux_n #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_sel       (bus_sel),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
`ifdef AXIS_MUX_PKT_CNT_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-channel source queues, the in-flight output FIFO
    // (capacity 2) and the packet lock.
    beat_t       src_q[NUM_CH][$];
    beat_t       buf_q[$];
    bit          hold[NUM_CH];
    bit          locked;
    int          lock_ch;
    logic [31:0] exp_pkts;
    int unsigned m_rdy_pct;
    int unsigned vld_pct;

    logic [NUM_CH-1:0] exp_tready;
    logic              exp_mvalid;
    beat_t             exp_beat;
    logic              exp_busy;

    int errors;
    int checks;

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            src_q[c].delete();
            hold[c] = 1'b0;
        end
        buf_q.delete();
        locked   = 1'b0;
        lock_ch  = 0;
        exp_pkts = '0;
    endtask

    task automatic load_pkt(input int ch, input int len, input logic [31:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? $urandom : base + 32'(i);
            b.keep = rnd ? 4'($urandom_range(1, 15)) : 4'hF;
            b.last = (i == len - 1);
            src_q[ch].push_back(b);
        end
    endtask

    // Drive this cycle's inputs and work out what the DUT must show.
    task automatic drive_and_predict();
        int act;
        for (int c = 0; c < NUM_CH; c++) begin
            if (src_q[c].size() > 0 && (hold[c] || $urandom_range(1, 100) <= vld_pct)) begin
                s_axis_tvalid[c]                   = 1'b1;
                s_axis_tdata[c*DATA_W +: DATA_W]   = src_q[c][0].data;
                s_axis_tkeep[c*KEEP_W +: KEEP_W]   = src_q[c][0].keep;
                s_axis_tlast[c]                    = src_q[c][0].last;
            end else begin
                s_axis_tvalid[c]                   = 1'b0;
                s_axis_tdata[c*DATA_W +: DATA_W]   = $urandom;
                s_axis_tkeep[c*KEEP_W +: KEEP_W]   = 4'($urandom);
                s_axis_tlast[c]                    = 1'($urandom);
            end
        end
        m_axis_tready = ($urandom_range(1, 100) <= m_rdy_pct);
        act = -1;
        if (locked) act = lock_ch;
        else if (bus_sel[7] && int'({25'd0, bus_sel[6:0]}) < NUM_CH) act = int'({25'd0, bus_sel[6:0]});
        exp_tready = '0;
        if (act >= 0 && buf_q.size() < 2) exp_tready[act] = 1'b1;
        exp_mvalid = (buf_q.size() > 0);
        exp_beat   = exp_mvalid ? buf_q[0] : '0;
        exp_busy   = locked;
        #1;
    endtask

    // Apply the handshakes the model predicts, then advance one clock.
    task automatic commit_cycle();
        beat_t b;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s_axis_tvalid[c]) begin
                if (exp_tready[c]) begin
                    b = src_q[c].pop_front();
                    buf_q.push_back(b);
                    hold[c] = 1'b0;
                    if (!locked && !b.last) begin
                        locked  = 1'b1;
                        lock_ch = c;
                    end else if (locked && b.last) begin
                        locked = 1'b0;
                    end
                end else begin
                    hold[c] = 1'b1;
                end
            end
        end
        if (exp_mvalid && m_axis_tready) begin
            b = buf_q.pop_front();
            if (b.last) exp_pkts = exp_pkts + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit pending();
        bit p = (buf_q.size() > 0);
        for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus_sel = 8'h00;
        s_axis_tvalid = '0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = '0;
        m_axis_tready = 1'b0;
        model_clear();
        #3;
        checks += 2;
        if ({m_axis_tvalid, m_axis_tlast, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got valid/last/busy=%b want 000", {m_axis_tvalid, m_axis_tlast, busy});
        end
        if ({m_axis_tdata, m_axis_tkeep} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {m_axis_tdata, m_axis_tkeep});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== '0) begin
            errors++;
            $display("FAIL reset_tready: got %b want 0", s_axis_tready);
        end
    endtask

    task automatic test_single_packet();
        bus_sel = 8'h82;
        m_rdy_pct = 100;
        vld_pct = 100;
        load_pkt(2, 3, 32'hA0, 1'b0);
        for (int n = 0; n < 12; n++) begin
            drive_and_predict();
            checks += 3;
            if (s_axis_tready !== exp_tready) begin errors++; $display("FAIL single_tready: got %b want %b", s_axis_tready, exp_tready); end
            if (m_axis_tvalid !== exp_mvalid) begin errors++; $display("FAIL single_mvalid: got %b want %b", m_axis_tvalid, exp_mvalid); end
            if (busy !== exp_busy) begin errors++; $display("FAIL single_busy: got %b want %b", busy, exp_busy); end
            if (exp_mvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== exp_beat) begin
                    errors++;
                    $display("FAIL single_beat: got %h want %h", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, exp_beat);
                end
            end
            commit_cycle();
        end
    endtask

    task automatic test_lock_switch();
        int n;
        bus_sel = 8'h81;
        m_rdy_pct = 100;
        vld_pct = 75;
        load_pkt(1, 4, 32'h0, 1'b1);
        load_pkt(4, 2, 32'h0, 1'b1);
        n = 0;
        while (pending() && n < 60) begin
            drive_and_predict();
            checks += 3;
            if (s_axis_tready !== exp_tready) begin errors++; $display("FAIL lock_tready: got %b want %b", s_axis_tready, exp_tready); end
            if (m_axis_tvalid !== exp_mvalid) begin errors++; $display("FAIL lock_mvalid: got %b want %b", m_axis_tvalid, exp_mvalid); end
            if (busy !== exp_busy) begin errors++; $display("FAIL lock_busy: got %b want %b", busy, exp_busy); end
            if (exp_mvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== exp_beat) begin
                    errors++;
                    $display("FAIL lock_beat: got %h want %h", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, exp_beat);
                end
            end
            commit_cycle();
            if (locked && lock_ch == 1) bus_sel = 8'h84;
            n++;
        end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL lock_timeout: got %0d cycles want <60", n); end
    endtask

    task automatic test_backpressure();
        int n;
        bus_sel = 8'h80;
        vld_pct = 100;
        load_pkt(0, 8, 32'h0, 1'b1);
        n = 0;
        while (pending() && n < 60) begin
            m_rdy_pct = (n >= 2 && n < 7) ? 0 : 100;
            drive_and_predict();
            checks += 3;
            if (s_axis_tready !== exp_tready) begin errors++; $display("FAIL bp_tready: got %b want %b", s_axis_tready, exp_tready); end
            if (m_axis_tvalid !== exp_mvalid) begin errors++; $display("FAIL bp_mvalid: got %b want %b", m_axis_tvalid, exp_mvalid); end
            if (busy !== exp_busy) begin errors++; $display("FAIL bp_busy: got %b want %b", busy, exp_busy); end
            if (exp_mvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== exp_beat) begin
                    errors++;
                    $display("FAIL bp_beat: got %h want %h", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, exp_beat);
                end
            end
            commit_cycle();
            n++;
        end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL bp_timeout: got %0d cycles want <60", n); end
    endtask

    task automatic test_invalid_sel();
        bus_sel = 8'h80;
        vld_pct = 100;
        load_pkt(0, 1, 32'h10, 1'b0);
        load_pkt(0, 1, 32'h11, 1'b0);
        for (int n = 0; n < 16; n++) begin
            m_rdy_pct = (n < 3) ? 0 : 100;
            if (n == 2) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    src_q[c].delete();
                    hold[c] = 1'b0;
                    load_pkt(c, 2, 32'h0, 1'b1);
                end
                bus_sel = 8'h06;
            end
            if (n == 9) bus_sel = 8'h86;
            drive_and_predict();
            checks += 3;
            if (s_axis_tready !== exp_tready) begin errors++; $display("FAIL inv_tready: got %b want %b", s_axis_tready, exp_tready); end
            if (m_axis_tvalid !== exp_mvalid) begin errors++; $display("FAIL inv_mvalid: got %b want %b", m_axis_tvalid, exp_mvalid); end
            if (busy !== exp_busy) begin errors++; $display("FAIL inv_busy: got %b want %b", busy, exp_busy); end
            if (exp_mvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== exp_beat) begin
                    errors++;
                    $display("FAIL inv_beat: got %h want %h", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, exp_beat);
                end
            end
            commit_cycle();
        end
        for (int c = 0; c < NUM_CH; c++) begin
            src_q[c].delete();
            hold[c] = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus_sel = 8'h83;
        vld_pct = 100;
        m_rdy_pct = 50;
        load_pkt(3, 6, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_and_predict();
            commit_cycle();
        end
        s_axis_tvalid = '0;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_mvalid: got %b want 0", m_axis_tvalid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_sel = 8'h80;
        m_rdy_pct = 100;
        load_pkt(0, 3, 32'hC0, 1'b0);
        n = 0;
        while (pending() && n < 30) begin
            drive_and_predict();
            checks += 3;
            if (s_axis_tready !== exp_tready) begin errors++; $display("FAIL rstmid_tready: got %b want %b", s_axis_tready, exp_tready); end
            if (m_axis_tvalid !== exp_mvalid) begin errors++; $display("FAIL rstmid_after_mvalid: got %b want %b", m_axis_tvalid, exp_mvalid); end
            if (busy !== exp_busy) begin errors++; $display("FAIL rstmid_after_busy: got %b want %b", busy, exp_busy); end
            if (exp_mvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== exp_beat) begin
                    errors++;
                    $display("FAIL rstmid_beat: got %h want %h", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, exp_beat);
                end
            end
            commit_cycle();
            n++;
        end
        checks++;
        if (n >= 30) begin errors++; $display("FAIL rstmid_timeout: got %0d cycles want <30", n); end
    endtask

    task automatic test_random();
        int n;
        m_rdy_pct = 70;
        vld_pct = 70;
        n = 0;
        while ((n < 400 || pending()) && n < 1400) begin
            if (n < 400) begin
                for (int c = 0; c < NUM_CH; c++)
                    if (src_q[c].size() == 0) load_pkt(c, $urandom_range(1, 4), 32'h0, 1'b1);
                if ($urandom_range(0, 7) == 0) bus_sel = 8'($urandom);
            end else begin
                for (int c = NUM_CH - 1; c >= 0; c--)
                    if (src_q[c].size() > 0) bus_sel = 8'h80 | 8'(c);
            end
            drive_and_predict();
            checks += 3;
            if (s_axis_tready !== exp_tready) begin errors++; $display("FAIL rand_tready: got %b want %b", s_axis_tready, exp_tready); end
            if (m_axis_tvalid !== exp_mvalid) begin errors++; $display("FAIL rand_mvalid: got %b want %b", m_axis_tvalid, exp_mvalid); end
            if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy: got %b want %b", busy, exp_busy); end
            if (exp_mvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== exp_beat) begin
                    errors++;
                    $display("FAIL rand_beat: got %h want %h", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, exp_beat);
                end
            end
            commit_cycle();
            n++;
        end
        checks++;
        if (n >= 1400) begin errors++; $display("FAIL rand_timeout: got %0d cycles want <1400", n); end
`ifdef AXIS_MUX_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== exp_pkts) begin errors++; $display("FAIL rand_pkt_cnt: got %h want %h", pkt_cnt, exp_pkts); end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_rdy_pct = 100;
        vld_pct = 100;
        test_reset();
        test_single_packet();
        test_lock_switch();
        test_backpressure();
        test_invalid_sel();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
